ela_row_feeder: RTL and testbench

ELA_ROW_FEEDER -- requirements
Module: ela_row_feeder

---
 rtl/ela_row_feeder_if.sv | 21 ++
 rtl/ela_row_feeder.sv | 103 ++++++++++
 tb/tb_ela_row_feeder.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/ela_row_feeder_if.sv
// Row-feeder bus: ELA core request/pixel stream plus frame-source memory port.
interface ela_row_feeder_if;
    logic       req;
    logic [8:0] rom_addr;
    logic [7:0] rom_data;
    logic [7:0] in_data;
    logic       in_valid;
    logic       busy;
    logic [3:0] row_idx;
    logic       eof;

    modport slave (
        input  req, rom_data,
        output rom_addr, in_data, in_valid, busy, row_idx, eof
    );

    modport master (
        output req, rom_data,
        input  rom_addr, in_data, in_valid, busy, row_idx, eof
    );
endinterface

// File: rtl/ela_row_feeder.sv
// Streams one frame row per request from a synchronous source memory to the ELA core,
// using a two-stage issue/read pipeline so pixels arrive gap-free in column order.
module ela_row_feeder #(
    parameter int ROW_W = 32,
    parameter int ROWS  = 16
) (
    input  logic clk,
    input  logic rst,
    ela_row_feeder_if.slave bus
);
    localparam int COL_W = (ROW_W > 1) ? $clog2(ROW_W) : 1;

    typedef enum logic [1:0] {IDLE, STREAM, END} state_t;

    state_t           state_q, state_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [8:0]       rom_addr_q, rom_addr_d;
    logic [3:0]       row_idx_q, row_idx_d;
    logic             eof_q, eof_d;
    logic             iss_q, iss_d;
    logic             rd_vld_q, rd_vld_d;
    logic             in_valid_q, in_valid_d;
    logic [7:0]       in_data_q, in_data_d;
    logic             busy_q, busy_d;

    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        rom_addr_d = rom_addr_q;
        row_idx_d  = row_idx_q;
        eof_d      = eof_q;
        iss_d      = 1'b0;
        // iss marks an address on the bus; rd_vld marks rom_data answering it.
        rd_vld_d   = iss_q;
        in_valid_d = rd_vld_q;
        in_data_d  = rd_vld_q ? bus.rom_data : in_data_q;

        case (state_q)
            IDLE: begin
                if (bus.req && !eof_q) begin
                    state_d    = STREAM;
                    rom_addr_d = 9'(row_idx_q) * 9'(ROW_W);
                    col_d      = '0;
                    iss_d      = 1'b1;
                end
            end
            STREAM: begin
                if (col_q == COL_W'(ROW_W - 1)) begin
                    // Last row holds row_idx rather than wrapping; eof marks completion.
                    if (row_idx_q == 4'(ROWS - 1)) begin
                        state_d = END;
                        eof_d   = 1'b1;
                    end else begin
                        row_idx_d = row_idx_q + 4'd1;
                        state_d   = IDLE;
                    end
                end else begin
                    col_d      = col_q + COL_W'(1);
                    rom_addr_d = rom_addr_q + 9'd1;
                    iss_d      = 1'b1;
                end
            end
            default: begin
                state_d = END;
            end
        endcase

        busy_d = iss_d | rd_vld_d | in_valid_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            col_q      <= '0;
            rom_addr_q <= '0;
            row_idx_q  <= '0;
            eof_q      <= 1'b0;
            iss_q      <= 1'b0;
            rd_vld_q   <= 1'b0;
            in_valid_q <= 1'b0;
            in_data_q  <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            rom_addr_q <= rom_addr_d;
            row_idx_q  <= row_idx_d;
            eof_q      <= eof_d;
            iss_q      <= iss_d;
            rd_vld_q   <= rd_vld_d;
            in_valid_q <= in_valid_d;
            in_data_q  <= in_data_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.rom_addr = rom_addr_q;
    assign bus.in_data  = in_data_q;
    assign bus.in_valid = in_valid_q;
    assign bus.busy     = busy_q;
    assign bus.row_idx  = row_idx_q;
    assign bus.eof      = eof_q;
endmodule

// File: tb/tb_ela_row_feeder.sv
// Self-checking bench for ela_row_feeder: a timeline model predicts, per clock edge,
// which pixel should appear and when busy is high; directed steps plus random requests.
`timescale 1ns/1ps
module tb_ela_row_feeder;
    localparam int ROW_W = 32;
    localparam int ROWS  = 16;
    localparam int FRAME = ROW_W * ROWS;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ela_row_feeder_if bus ();

    ela_row_feeder #(.ROW_W(ROW_W), .ROWS(ROWS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0] mem [FRAME];
    always @(posedge clk) bus.rom_data <= mem[bus.rom_addr];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Index of the most recent rising edge (first edge at t=5).
    function automatic int edge_now();
        return int'(($time - 5) / 10);
    endfunction

    typedef struct { int e; logic [7:0] d; } pix_t;
    pix_t       exp_q[$];
    int         m_rows   = 0;
    int         m_free   = 0;
    int         m_bsy_lo = 1;
    int         m_bsy_hi = 0;
    logic [7:0] m_last   = 8'h00;
    int         pix_cnt  = 0;

    // Model: a request accepted at edge e yields pixel k after edge e+2+k and
    // keeps busy high after edges e..e+ROW_W+1; next acceptance no earlier than e+ROW_W+1.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q.delete();
            m_rows   = 0;
            m_free   = 0;
            m_bsy_lo = 1;
            m_bsy_hi = 0;
            m_last   = 8'h00;
        end else begin
            int e;
            e = edge_now();
            if (bus.req && m_rows < ROWS && e >= m_free) begin
                for (int k = 0; k < ROW_W; k++)
                    exp_q.push_back('{e: e + 2 + k, d: mem[m_rows * ROW_W + k]});
                m_free   = e + ROW_W + 1;
                m_bsy_lo = e;
                m_bsy_hi = e + ROW_W + 1;
                m_rows++;
            end
        end
    end

    always @(negedge clk) begin
        int   e;
        logic exp_v;
        e     = edge_now();
        exp_v = (exp_q.size() > 0) && (exp_q[0].e == e);
        chk("in_valid", 32'(bus.in_valid), 32'(exp_v));
        chk("busy", 32'(bus.busy), 32'(e >= m_bsy_lo && e <= m_bsy_hi));
        if (exp_v) begin
            m_last = exp_q[0].d;
            void'(exp_q.pop_front());
            pix_cnt++;
        end
        chk("in_data", 32'(bus.in_data), 32'(m_last));
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic quiet_checks(input string tag);
        chk({tag, "_row_idx"}, 32'(bus.row_idx), 32'(m_rows));
        chk({tag, "_eof"}, 32'(bus.eof), 32'(m_rows == ROWS));
        chk({tag, "_busy"}, 32'(bus.busy), 32'(0));
        chk({tag, "_drained"}, 32'(exp_q.size()), 32'(0));
    endtask

    initial begin
        int pc0;
        bus.req = 1'b0;
        for (int i = 0; i < FRAME; i++) mem[i] = 8'($urandom);

        // Reset state
        tick(3);
        chk("rst_rom_addr", 32'(bus.rom_addr), 32'(0));
        chk("rst_in_valid", 32'(bus.in_valid), 32'(0));
        chk("rst_in_data", 32'(bus.in_data), 32'(0));
        chk("rst_busy", 32'(bus.busy), 32'(0));
        chk("rst_row_idx", 32'(bus.row_idx), 32'(0));
        chk("rst_eof", 32'(bus.eof), 32'(0));
        // req held across the release edge must not start a row
        bus.req = 1'b1;
        tick(1);
        rst = 1'b0;
        bus.req = 1'b0;
        tick(2);
        chk("req_during_rst", 32'(bus.busy), 32'(0));

        // Single request: addresses 0.. issued one per edge
        bus.req = 1'b1;
        tick(1);
        bus.req = 1'b0;
        chk("addr_T", 32'(bus.rom_addr), 32'(0));
        tick(1);
        chk("addr_T1", 32'(bus.rom_addr), 32'(1));
        tick(ROW_W + 4);
        quiet_checks("row0");

        // Requests while busy are dropped
        pc0 = pix_cnt;
        bus.req = 1'b1; tick(1); bus.req = 1'b0;
        chk("addr_row1", 32'(bus.rom_addr), 32'(ROW_W));
        tick(4);  bus.req = 1'b1; tick(1); bus.req = 1'b0;
        tick(14); bus.req = 1'b1; tick(1); bus.req = 1'b0;
        tick(ROW_W);
        chk("busy_pulse_pixels", 32'(pix_cnt - pc0), 32'(ROW_W));
        quiet_checks("row1");

        // Random request traffic
        for (int c = 0; c < 300; c++) begin
            bus.req = ($urandom_range(0, 3) == 0);
            tick(1);
        end
        bus.req = 1'b0;
        tick(ROW_W + 4);
        quiet_checks("random");

        // Reset in the middle of row 3, then restart from row 0
        rst = 1'b1; tick(1); rst = 1'b0;
        bus.req = 1'b1;
        tick(3 * (ROW_W + 1) + 10);
        rst = 1'b1;
        #1;
        chk("abort_in_valid", 32'(bus.in_valid), 32'(0));
        chk("abort_busy", 32'(bus.busy), 32'(0));
        chk("abort_row_idx", 32'(bus.row_idx), 32'(0));
        bus.req = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(2);
        chk("abort_quiet", 32'(bus.in_valid), 32'(0));
        bus.req = 1'b1; tick(1); bus.req = 1'b0;
        tick(ROW_W + 4);
        quiet_checks("restart");

        // Full frame with the address-derived pattern, req held high
        for (int i = 0; i < FRAME; i++) mem[i] = 8'(i) ^ 8'hA5;
        rst = 1'b1; tick(1); rst = 1'b0;
        pc0 = pix_cnt;
        bus.req = 1'b1;
        tick(ROWS * (ROW_W + 1) + 6);
        chk("frame_pixels", 32'(pix_cnt - pc0), 32'(FRAME));
        chk("frame_eof", 32'(bus.eof), 32'(1));
        chk("frame_drained", 32'(exp_q.size()), 32'(0));
        tick(50);
        bus.req = 1'b0;
        chk("end_no_pixels", 32'(pix_cnt - pc0), 32'(FRAME));
        chk("end_busy", 32'(bus.busy), 32'(0));
        chk("end_eof", 32'(bus.eof), 32'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
